// File: rtl/mem_access.sv
// MEM stage: data-bus req/ack transaction, upstream stall, load alignment
// and extension, registered writeback bundle toward WB.
module mem_access #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  EX_rd,
  input  logic [31:0] EX_x_rd,
  input  logic        EX_x_rd_vld,
  input  logic [31:0] EX_MEM_addr,
  input  logic [3:0]  EX_MEM_rden,
  input  logic        EX_MEM_rden_SEXT,
  input  logic [3:0]  EX_MEM_wren,
  input  logic [31:0] EX_MEM_wrdata,
  output logic        mem_stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  MEM_rd,
  output logic [31:0] MEM_x_rd,
  output logic        MEM_x_rd_vld,
  output logic        MEM_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic        req_q, we_q, vld_q, err_q;
  logic [31:0] addr_q, wdata_q, x_q;
  logic [3:0]  be_q;
  logic [4:0]  rd_q;

  logic        op, timeout_hit, rden_bad, ext;
  logic [31:0] load_data;
  logic        unused_addr;

  assign unused_addr = ^EX_MEM_addr[1:0];

  assign op = (|EX_MEM_rden) | (|EX_MEM_wren);

  assign timeout_hit = (TIMEOUT != 0) && (state_q == WAIT) && !dbus_ack
                    && (cnt_q == CNT_W'(TIMEOUT - 1));

  assign mem_stall = ((state_q == IDLE) & op)
                   | ((state_q == WAIT) & ~dbus_ack & ~timeout_hit);

  always_comb begin
    load_data = '0;
    rden_bad  = 1'b0;
    ext       = 1'b0;
    case (EX_MEM_rden)
      4'b1111: load_data = dbus_rdata;
      4'b0011: begin
        ext       = EX_MEM_rden_SEXT & dbus_rdata[15];
        load_data = {{16{ext}}, dbus_rdata[15:0]};
      end
      4'b1100: begin
        ext       = EX_MEM_rden_SEXT & dbus_rdata[31];
        load_data = {{16{ext}}, dbus_rdata[31:16]};
      end
      4'b0001: begin
        ext       = EX_MEM_rden_SEXT & dbus_rdata[7];
        load_data = {{24{ext}}, dbus_rdata[7:0]};
      end
      4'b0010: begin
        ext       = EX_MEM_rden_SEXT & dbus_rdata[15];
        load_data = {{24{ext}}, dbus_rdata[15:8]};
      end
      4'b0100: begin
        ext       = EX_MEM_rden_SEXT & dbus_rdata[23];
        load_data = {{24{ext}}, dbus_rdata[23:16]};
      end
      4'b1000: begin
        ext       = EX_MEM_rden_SEXT & dbus_rdata[31];
        load_data = {{24{ext}}, dbus_rdata[31:24]};
      end
      default: rden_bad = |EX_MEM_rden;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      x_q     <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op) begin
            req_q   <= 1'b1;
            we_q    <= |EX_MEM_wren;
            addr_q  <= {EX_MEM_addr[31:2], 2'b00};
            be_q    <= (|EX_MEM_wren) ? EX_MEM_wren : EX_MEM_rden;
            wdata_q <= EX_MEM_wrdata;
            vld_q   <= 1'b0;
            err_q   <= (|EX_MEM_wren) & (|EX_MEM_rden);
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            rd_q  <= EX_rd;
            x_q   <= EX_x_rd;
            vld_q <= EX_x_rd_vld;
          end
        end
        WAIT: begin
          if (dbus_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
            rd_q    <= EX_rd;
            vld_q   <= EX_x_rd_vld;
            if (we_q) begin
              x_q <= EX_x_rd;
            end else begin
              x_q   <= load_data;
              err_q <= rden_bad;
            end
          end else if (timeout_hit) begin
            // abort: no writeback, flag the error
            req_q   <= 1'b0;
            state_q <= IDLE;
            vld_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign dbus_req     = req_q;
  assign dbus_we      = we_q;
  assign dbus_addr    = addr_q;
  assign dbus_be      = be_q;
  assign dbus_wdata   = wdata_q;
  assign MEM_rd       = rd_q;
  assign MEM_x_rd     = x_q;
  assign MEM_x_rd_vld = vld_q;
  assign MEM_err      = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table of single-ack transactions
// plus hand sequences for wait states, timeout and async reset.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  EX_rd;
  logic [31:0] EX_x_rd;
  logic        EX_x_rd_vld;
  logic [31:0] EX_MEM_addr;
  logic [3:0]  EX_MEM_rden;
  logic        EX_MEM_rden_SEXT;
  logic [3:0]  EX_MEM_wren;
  logic [31:0] EX_MEM_wrdata;
  logic        mem_stall;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [4:0]  MEM_rd;
  logic [31:0] MEM_x_rd;
  logic        MEM_x_rd_vld;
  logic        MEM_err;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .EX_rd(EX_rd), .EX_x_rd(EX_x_rd), .EX_x_rd_vld(EX_x_rd_vld),
    .EX_MEM_addr(EX_MEM_addr), .EX_MEM_rden(EX_MEM_rden),
    .EX_MEM_rden_SEXT(EX_MEM_rden_SEXT), .EX_MEM_wren(EX_MEM_wren),
    .EX_MEM_wrdata(EX_MEM_wrdata), .mem_stall(mem_stall),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .MEM_rd(MEM_rd), .MEM_x_rd(MEM_x_rd),
    .MEM_x_rd_vld(MEM_x_rd_vld), .MEM_err(MEM_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    EX_rd            = '0;
    EX_x_rd          = '0;
    EX_x_rd_vld      = 1'b0;
    EX_MEM_addr      = '0;
    EX_MEM_rden      = '0;
    EX_MEM_rden_SEXT = 1'b0;
    EX_MEM_wren      = '0;
    EX_MEM_wrdata    = '0;
    dbus_ack         = 1'b0;
    dbus_rdata       = '0;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] xrd;
    logic        vld;
    logic [31:0] addr;
    logic [3:0]  rden;
    logic        sext;
    logic [3:0]  wren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_x;
    logic        e_vld;
    logic        e_err1;
    logic        e_err2;
  } vec_t;

  vec_t vt[12];

  initial begin
    idle_in();
    //        rd  xrd           vld addr          rden    sx wren    wdata         rdata         e_addr        e_be    we e_x           ev e1 e2
    vt[0]  = '{5,  32'h0000_1234, 1, 32'h0,        4'b0000, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        4'b0000, 0, 32'h0000_1234, 1, 0, 0};
    vt[1]  = '{7,  32'h0,        1, 32'h0000_0103, 4'b1000, 1, 4'b0000, 32'h0,        32'h80AA_BBCC, 32'h0000_0100, 4'b1000, 0, 32'hFFFF_FF80, 1, 0, 0};
    vt[2]  = '{8,  32'h0,        1, 32'h0000_0200, 4'b0001, 0, 4'b0000, 32'h0,        32'h80AA_BBCC, 32'h0000_0200, 4'b0001, 0, 32'h0000_00CC, 1, 0, 0};
    vt[3]  = '{9,  32'h0,        1, 32'h0000_0301, 4'b0010, 1, 4'b0000, 32'h0,        32'h80AA_BBCC, 32'h0000_0300, 4'b0010, 0, 32'hFFFF_FFBB, 1, 0, 0};
    vt[4]  = '{10, 32'h0,        1, 32'h0000_0402, 4'b0100, 1, 4'b0000, 32'h0,        32'h80AA_BBCC, 32'h0000_0400, 4'b0100, 0, 32'hFFFF_FFAA, 1, 0, 0};
    vt[5]  = '{11, 32'h0,        1, 32'h0000_0500, 4'b0011, 1, 4'b0000, 32'h0,        32'h1234_8001, 32'h0000_0500, 4'b0011, 0, 32'hFFFF_8001, 1, 0, 0};
    vt[6]  = '{12, 32'h0,        1, 32'h0000_0604, 4'b1111, 0, 4'b0000, 32'h0,        32'hCAFE_F00D, 32'h0000_0604, 4'b1111, 0, 32'hCAFE_F00D, 1, 0, 0};
    vt[7]  = '{0,  32'h0000_0055, 0, 32'h0000_0700, 4'b0000, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        32'h0000_0700, 4'b1111, 1, 32'h0000_0055, 0, 0, 0};
    vt[8]  = '{13, 32'h0000_0077, 1, 32'h0000_0806, 4'b0000, 0, 4'b0100, 32'h1111_1111, 32'h0,        32'h0000_0804, 4'b0100, 1, 32'h0000_0077, 1, 0, 0};
    vt[9]  = '{14, 32'h0000_0099, 0, 32'h0000_0900, 4'b0001, 0, 4'b0001, 32'h2222_2222, 32'h5555_5555, 32'h0000_0900, 4'b0001, 1, 32'h0000_0099, 0, 1, 0};
    vt[10] = '{15, 32'h0,        1, 32'h0000_0A01, 4'b0110, 0, 4'b0000, 32'h0,        32'h1234_5678, 32'h0000_0A00, 4'b0110, 0, 32'h0000_0000, 1, 0, 1};
    vt[11] = '{3,  32'h0000_ABCD, 0, 32'h0,        4'b0000, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        4'b0000, 0, 32'h0000_ABCD, 0, 0, 0};

    #3;
    chk("rst_req", 32'(dbus_req), 32'd0);
    chk("rst_addr", dbus_addr, 32'h0);
    chk("rst_be", 32'(dbus_be), 32'd0);
    chk("rst_wd", dbus_wdata, 32'h0);
    chk("rst_x", MEM_x_rd, 32'h0);
    chk("rst_vld", 32'(MEM_x_rd_vld), 32'd0);
    chk("rst_err", 32'(MEM_err), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    #9 rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      logic op;
      EX_rd            = vt[i].rd;
      EX_x_rd          = vt[i].xrd;
      EX_x_rd_vld      = vt[i].vld;
      EX_MEM_addr      = vt[i].addr;
      EX_MEM_rden      = vt[i].rden;
      EX_MEM_rden_SEXT = vt[i].sext;
      EX_MEM_wren      = vt[i].wren;
      EX_MEM_wrdata    = vt[i].wdata;
      op = (vt[i].rden != 0) || (vt[i].wren != 0);
      #1;
      chk($sformatf("v%0d_stall0", i), 32'(mem_stall), 32'(op));
      tick();
      if (op) begin
        chk($sformatf("v%0d_req", i), 32'(dbus_req), 32'd1);
        chk($sformatf("v%0d_addr", i), dbus_addr, vt[i].e_addr);
        chk($sformatf("v%0d_be", i), 32'(dbus_be), 32'(vt[i].e_be));
        chk($sformatf("v%0d_we", i), 32'(dbus_we), 32'(vt[i].e_we));
        chk($sformatf("v%0d_wd", i), dbus_wdata, vt[i].wdata);
        chk($sformatf("v%0d_bub", i), 32'(MEM_x_rd_vld), 32'd0);
        chk($sformatf("v%0d_err1", i), 32'(MEM_err), 32'(vt[i].e_err1));
        dbus_ack   = 1'b1;
        dbus_rdata = vt[i].rdata;
        #1;
        chk($sformatf("v%0d_stall1", i), 32'(mem_stall), 32'd0);
        tick();
        dbus_ack = 1'b0;
        chk($sformatf("v%0d_reqdn", i), 32'(dbus_req), 32'd0);
      end
      chk($sformatf("v%0d_rd", i), 32'(MEM_rd), 32'(vt[i].rd));
      chk($sformatf("v%0d_x", i), MEM_x_rd, vt[i].e_x);
      chk($sformatf("v%0d_vld", i), 32'(MEM_x_rd_vld), 32'(vt[i].e_vld));
      chk($sformatf("v%0d_err2", i), 32'(MEM_err), 32'(vt[i].e_err2));
      idle_in();
    end
    tick();

    // LHU with three WAIT cycles before ack
    begin
      int n = 0;
      EX_rd       = 5'd9;
      EX_x_rd_vld = 1'b1;
      EX_MEM_addr = 32'h0000_0202;
      EX_MEM_rden = 4'b1100;
      for (int c = 0; c < 5; c++) begin
        if (c == 4) begin
          dbus_ack   = 1'b1;
          dbus_rdata = 32'hF00D_1234;
        end
        #1;
        if (mem_stall) n++;
        if (c < 4) tick();
      end
      chk("lhu_stallcnt", 32'(n), 32'd4);
      tick();
      dbus_ack = 1'b0;
      chk("lhu_x", MEM_x_rd, 32'h0000_F00D);
      chk("lhu_vld", 32'(MEM_x_rd_vld), 32'd1);
      chk("lhu_rd", 32'(MEM_rd), 32'd9);
      idle_in();
      tick();
    end

    // bus timeout with TIMEOUT=4
    begin
      int n = 0;
      EX_rd       = 5'd4;
      EX_x_rd_vld = 1'b1;
      EX_MEM_addr = 32'h0000_0B00;
      EX_MEM_rden = 4'b1111;
      tick();
      while (dbus_req && n < 20) begin
        n++;
        if (n == 4) chk("to_stall_hit", 32'(mem_stall), 32'd0);
        tick();
      end
      idle_in();
      #1;
      chk("to_reqcnt", 32'(n), 32'd4);
      chk("to_err", 32'(MEM_err), 32'd1);
      chk("to_vld", 32'(MEM_x_rd_vld), 32'd0);
      chk("to_stall", 32'(mem_stall), 32'd0);
      tick();
      chk("to_errpulse", 32'(MEM_err), 32'd0);
      chk("to_idle_req", 32'(dbus_req), 32'd0);
    end

    // async reset while WAIT, then a late ack
    begin
      EX_MEM_addr = 32'h0000_0C00;
      EX_MEM_rden = 4'b0001;
      tick();
      chk("ar_req_pre", 32'(dbus_req), 32'd1);
      #2 rst = 1'b1;
      idle_in();
      #1;
      chk("ar_req", 32'(dbus_req), 32'd0);
      chk("ar_stall", 32'(mem_stall), 32'd0);
      #1 rst = 1'b0;
      dbus_ack   = 1'b1;
      dbus_rdata = 32'h0000_00FF;
      tick();
      dbus_ack = 1'b0;
      chk("ar_vld", 32'(MEM_x_rd_vld), 32'd0);
      chk("ar_x", MEM_x_rd, 32'h0);
      chk("ar_err", 32'(MEM_err), 32'd0);
      chk("ar_req2", 32'(dbus_req), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the RV32 in-order pipeline, directly downstream of the execute stage.
- Consumes the execute stage's registered memory controls (address, per-byte read/write enables, sign-extend flag) plus the rd/x_rd writeback bundle.
- Runs a req/ack transaction on the data bus and stalls upstream while the transaction is outstanding.
- Aligns and sign/zero-extends load data, and presents one registered writeback bundle to the WB stage.

Parameters:
TIMEOUT, 255, max WAIT cycles without dbus_ack before abort; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
EX_rd  in  5  destination register from execute
EX_x_rd  in  32  ALU/jump result from execute
EX_x_rd_vld  in  1  writeback valid from execute
EX_MEM_addr  in  32  byte address of load/store
EX_MEM_rden  in  4  per-byte-lane read enable
EX_MEM_rden_SEXT  in  1  1 = sign-extend load (lb/lh)
EX_MEM_wren  in  4  per-byte-lane write enable
EX_MEM_wrdata  in  32  lane-replicated store data
mem_stall  out  1  combinational; upstream freezes all its output registers while high
dbus_req  out  1  bus request, registered
dbus_we  out  1  1 = write
dbus_addr  out  32  {EX_MEM_addr[31:2],2'b00}
dbus_be  out  4  byte enables (wren for stores, rden for loads)
dbus_wdata  out  32  store data
dbus_ack  in  1  bus completion, one cycle; rdata valid same cycle
dbus_rdata  in  32  read word
MEM_rd  out  5  registered writeback register index
MEM_x_rd  out  32  registered writeback data
MEM_x_rd_vld  out  1  registered writeback valid
MEM_err  out  1  one-cycle pulse on bus timeout or illegal enable pattern

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0. All registered outputs are 0: dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, MEM_rd, MEM_x_rd, MEM_x_rd_vld, MEM_err.
- Reset mid-transaction: immediately abandons the transaction and drops dbus_req. Any late dbus_ack after reset is ignored.
- op = |EX_MEM_rden | |EX_MEM_wren.
- mem_stall = (IDLE & op) | (WAIT & ~dbus_ack & ~timeout_hit).
- IDLE, op=0 (pass-through): next edge MEM_rd<=EX_rd, MEM_x_rd<=EX_x_rd, MEM_x_rd_vld<=EX_x_rd_vld. One-cycle latency.
- IDLE, op=1:
  - Next edge: dbus_req<=1, dbus_addr/dbus_be/dbus_wdata/dbus_we loaded, state<=WAIT, counter<=0, MEM_x_rd_vld<=0 (bubble).
  - Store priority: if wren!=0 then dbus_we=1 and dbus_be=wren; otherwise dbus_we=0 and dbus_be=rden.
  - wren and rden both nonzero: treated as a store, MEM_err pulses.
- WAIT:
  - Bus signals held stable. Upstream inputs are stable because mem_stall is high.
  - counter increments each cycle without ack.
  - Ack on the first WAIT cycle is legal, giving a minimum load-to-writeback latency of 2 cycles.
- WAIT with dbus_ack:
  - mem_stall is low that cycle.
  - Next edge: dbus_req<=0, state<=IDLE, MEM_rd<=EX_rd, MEM_x_rd_vld<=EX_x_rd_vld.
  - MEM_x_rd <= load_data for loads, EX_x_rd for stores.
- timeout_hit = TIMEOUT!=0 & WAIT & ~dbus_ack & counter==TIMEOUT-1.
  - On hit: treated as completion with MEM_x_rd_vld<=0, MEM_err<=1, dbus_req<=0, state<=IDLE.
- dbus_ack outside WAIT is ignored.
- load_data by rden; ext = sign bit if EX_MEM_rden_SEXT, else 0:
  - 1111 -> rdata.
  - 0011 -> {16{ext},rdata[15:0]}; 1100 -> {16{ext},rdata[31:16]}.
  - 0001/0010/0100/1000 -> byte lane 0/1/2/3 extended from that byte's bit 7.
  - Any other nonzero pattern -> 0 and MEM_err pulse at writeback.
- MEM_err is a one-cycle pulse; otherwise 0.

Test Plan:
- Pass-through ADD: EX_rd=5, EX_x_rd=0x1234, vld=1, no op -> next cycle MEM_rd=5, MEM_x_rd=0x1234, MEM_x_rd_vld=1; mem_stall stays 0.
- LB sext: addr=0x103, rden=1000, SEXT=1, ack on the first WAIT cycle with rdata=0x80AABBCC -> dbus_addr=0x100, dbus_be=1000, mem_stall high 1 cycle, MEM_x_rd=0xFFFFFF80 two cycles after op.
- LHU with 3-cycle ack delay: rden=1100, SEXT=0, rdata=0xF00D1234 -> mem_stall high 4 cycles, MEM_x_rd=0x0000F00D.
- SW: wren=1111, wrdata=0xDEADBEEF, vld=0 -> dbus_we=1, dbus_be=1111, dbus_wdata=0xDEADBEEF, MEM_x_rd_vld=0 after ack.
- Timeout: TIMEOUT=4, load with no ack -> dbus_req high exactly 4 cycles, then MEM_err=1 for 1 cycle, MEM_x_rd_vld=0, mem_stall falls, state returns IDLE.
- Async reset in WAIT: assert rst between edges -> dbus_req=0, mem_stall=0 immediately; a subsequent ack produces no writeback.
